// File: rtl/taxi_pkg.sv
// ---------------------------------------------------------------------------
// taxi_pkg
// Shared definitions for the waiting-fare path: FSM state encoding, default
// counter widths and the charge-unit increments fed into the pending queue.
// ---------------------------------------------------------------------------
package taxi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FREE = 2'd1,
    ST_BILL = 2'd2
  } wf_state_t;

  localparam int unsigned WF_CNT_W  = 8;
  localparam int unsigned WF_PEND_W = 4;

  // Charge units added to the pending counter per billing step.
  localparam logic [1:0] CHARGE_NONE  = 2'd0;
  localparam logic [1:0] CHARGE_DAY   = 2'd1;
  localparam logic [1:0] CHARGE_NIGHT = 2'd2;

endpackage

// File: rtl/charge_queue.sv
// ---------------------------------------------------------------------------
// charge_queue
// Pending charge-unit counter with req/ack handshake towards the fare
// accumulator. Saturates at all-ones; any unit that does not fit sets the
// sticky pend_ovf flag (cleared only by rst).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   add          charge units to add this cycle (0..2)
//   charge_ack   accumulator takes one unit (honoured only while charge_req)
//   charge_req   registered, high while pending != 0
//   pend_ovf     sticky: a charge unit was lost to saturation
// ---------------------------------------------------------------------------
module charge_queue
  import taxi_pkg::*;
#(
  parameter int unsigned PEND_W = WF_PEND_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] add,
  input  logic       charge_ack,
  output logic       charge_req,
  output logic       pend_ovf
);

  localparam int unsigned SUM_W = PEND_W + 2;
  localparam logic [SUM_W-1:0] PEND_MAX = {2'b00, {PEND_W{1'b1}}};

  logic [PEND_W-1:0] r_pend;
  logic              r_req;
  logic              r_ovf;

  logic              w_ack_ok;
  logic [SUM_W-1:0]  w_sum;
  logic              w_lost;
  logic [PEND_W-1:0] w_pend_nxt;

  // r_req mirrors (r_pend != 0), so an accepted ack never underflows w_sum.
  assign w_ack_ok = charge_ack & r_req;

  always_comb begin
    w_sum      = SUM_W'(r_pend) + SUM_W'(add) - SUM_W'(w_ack_ok);
    w_lost     = (w_sum > PEND_MAX);
    w_pend_nxt = w_lost ? '1 : w_sum[PEND_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_req  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_req  <= (w_pend_nxt != '0);
      r_ovf  <= r_ovf | w_lost;
    end
  end

  assign charge_req = r_req;
  assign pend_ovf   = r_ovf;

endmodule

// File: rtl/wait_fare_timer.sv
// ---------------------------------------------------------------------------
// wait_fare_timer
// Counts waiting minutes (engaged and stopped) from the divider's minute
// strobe, skips a free-wait window, then turns every BILL_STEP billed minutes
// into charge units handed to the fare accumulator via charge_req/ack.
// sat feeds the divider's max input so it stops once wait_min is full.
//
// Optional feature (macro NIGHT_RATE_EN): adds input `night`; while high each
// billing step adds 2 charge units instead of 1.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           trip in service; low ends the trip
//   moving       vehicle moving; minutes not counted
//   min_pulse    one-cycle minute strobe
//   night        (NIGHT_RATE_EN only) double-rate billing
//   charge_ack   accumulator accepts one charge unit
//   charge_req   at least one charge unit pending
//   wait_min     waiting minutes this trip
//   sat          wait_min is all-ones
//   billing      FSM in BILL
//   pend_ovf     sticky: charge unit lost to pending saturation
// ---------------------------------------------------------------------------
module wait_fare_timer
  import taxi_pkg::*;
#(
  parameter int unsigned FREE_MIN  = 3,
  parameter int unsigned BILL_STEP = 1,
  parameter int unsigned CNT_W     = WF_CNT_W,
  parameter int unsigned PEND_W    = WF_PEND_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             moving,
  input  logic             min_pulse,
`ifdef NIGHT_RATE_EN
  input  logic             night,
`endif
  input  logic             charge_ack,
  output logic             charge_req,
  output logic [CNT_W-1:0] wait_min,
  output logic             sat,
  output logic             billing,
  output logic             pend_ovf
);

  localparam int unsigned STEP_W = (BILL_STEP > 1) ? $clog2(BILL_STEP) : 1;
  localparam logic [CNT_W-1:0]  FREE_LAST = (FREE_MIN > 0) ? CNT_W'(FREE_MIN - 1) : '0;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BILL_STEP - 1);

  wf_state_t         r_state;
  wf_state_t         w_state_nxt;
  logic [CNT_W-1:0]  r_wait_min;
  logic              r_sat;
  logic [STEP_W-1:0] r_step_cnt;

  logic              w_tick;
  logic [CNT_W-1:0]  w_wait_inc;
  logic              w_step_done;
  logic [1:0]        w_add;

  assign w_tick      = en & ~moving & min_pulse & ~r_sat;
  assign w_wait_inc  = r_wait_min + CNT_W'(1);
  // Only ticks seen while already in BILL are billed; the FREE->BILL tick is free.
  assign w_step_done = (r_state == ST_BILL) && w_tick && (r_step_cnt == STEP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (en) w_state_nxt = (FREE_MIN == 0) ? ST_BILL : ST_FREE;
      end
      ST_FREE: begin
        if (!en)                                   w_state_nxt = ST_IDLE;
        else if (w_tick && r_wait_min == FREE_LAST) w_state_nxt = ST_BILL;
      end
      ST_BILL: begin
        if (!en) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_min <= '0;
      r_sat      <= 1'b0;
      r_step_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_wait_min <= '0;
      r_sat      <= 1'b0;
      r_step_cnt <= '0;
    end else if (w_tick) begin
      // w_tick already excludes r_sat, so the increment never wraps.
      r_wait_min <= w_wait_inc;
      r_sat      <= &w_wait_inc;
      if (r_state == ST_BILL) begin
        r_step_cnt <= w_step_done ? '0 : r_step_cnt + STEP_W'(1);
      end
    end
  end

`ifdef NIGHT_RATE_EN
  assign w_add = !w_step_done ? CHARGE_NONE : (night ? CHARGE_NIGHT : CHARGE_DAY);
`else
  assign w_add = w_step_done ? CHARGE_DAY : CHARGE_NONE;
`endif

  charge_queue #(
    .PEND_W (PEND_W)
  ) u_charge_queue (
    .clk        (clk),
    .rst        (rst),
    .add        (w_add),
    .charge_ack (charge_ack),
    .charge_req (charge_req),
    .pend_ovf   (pend_ovf)
  );

  assign wait_min = r_wait_min;
  assign sat      = r_sat;
  assign billing  = (r_state == ST_BILL);

endmodule

// File: tb/tb_wait_fare_timer.sv
// ---------------------------------------------------------------------------
// tb_wait_fare_timer
// Three instances: A defaults, B (CNT_W=3, FREE_MIN=0, ack tied high),
// C (PEND_W=2, FREE_MIN=0). Stimulus pushes expected snapshots into a queue;
// a monitor process pops and compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_wait_fare_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_en, a_mov, a_pulse, a_ack, a_req, a_sat, a_bill, a_ovf;
  logic [7:0] a_wmin;
  logic       b_en, b_mov, b_pulse, b_ack, b_req, b_sat, b_bill, b_ovf;
  logic [2:0] b_wmin;
  logic       c_en, c_mov, c_pulse, c_ack, c_req, c_sat, c_bill, c_ovf;
  logic [7:0] c_wmin;

  wait_fare_timer u_a (
    .clk(clk), .rst(rst), .en(a_en), .moving(a_mov), .min_pulse(a_pulse),
    .charge_ack(a_ack), .charge_req(a_req), .wait_min(a_wmin), .sat(a_sat),
    .billing(a_bill), .pend_ovf(a_ovf)
  );

  wait_fare_timer #(.FREE_MIN(0), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .moving(b_mov), .min_pulse(b_pulse),
    .charge_ack(b_ack), .charge_req(b_req), .wait_min(b_wmin), .sat(b_sat),
    .billing(b_bill), .pend_ovf(b_ovf)
  );

  wait_fare_timer #(.FREE_MIN(0), .PEND_W(2)) u_c (
    .clk(clk), .rst(rst), .en(c_en), .moving(c_mov), .min_pulse(c_pulse),
    .charge_ack(c_ack), .charge_req(c_req), .wait_min(c_wmin), .sat(c_sat),
    .billing(c_bill), .pend_ovf(c_ovf)
  );

  // Accepted handshakes per instance (req and ack both high at a clock edge).
  int acks_a = 0, acks_b = 0, acks_c = 0;
  always @(posedge clk) begin
    if (!rst && a_req && a_ack) acks_a++;
    if (!rst && b_req && b_ack) acks_b++;
    if (!rst && c_req && c_ack) acks_c++;
  end

  typedef struct {
    string name;
    int    dut;
    int    wmin;
    bit    req;
    bit    sat;
    bit    bill;
    bit    ovf;
    int    acks;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Monitor: pops every queued expectation and compares with the live outputs.
  initial begin
    exp_t e;
    int   aw, ak;
    logic ar, as, ab, ao;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.dut)
          0:       begin aw = int'(a_wmin); ar = a_req; as = a_sat; ab = a_bill; ao = a_ovf; ak = acks_a; end
          1:       begin aw = int'(b_wmin); ar = b_req; as = b_sat; ab = b_bill; ao = b_ovf; ak = acks_b; end
          default: begin aw = int'(c_wmin); ar = c_req; as = c_sat; ab = c_bill; ao = c_ovf; ak = acks_c; end
        endcase
        n_chk++;
        if (aw == e.wmin && ar === e.req && as === e.sat && ab === e.bill &&
            ao === e.ovf && ak == e.acks) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got wmin=%0d req=%b sat=%b bill=%b ovf=%b acks=%0d, expected wmin=%0d req=%b sat=%b bill=%b ovf=%b acks=%0d",
                   e.name, aw, ar, as, ab, ao, ak,
                   e.wmin, e.req, e.sat, e.bill, e.ovf, e.acks);
        end
      end
    end
  end

  task automatic expect_st(input string nm, input int d, input int w, input bit rq,
                           input bit st, input bit bl, input bit ov, input int ak);
    exp_t e;
    e.name = nm; e.dut = d; e.wmin = w; e.req = rq;
    e.sat = st; e.bill = bl; e.ovf = ov; e.acks = ak;
    q.push_back(e);
    -> chk_ev;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle minute strobe followed by one idle cycle.
  task automatic p_a(); a_pulse = 1'b1; cyc(); a_pulse = 1'b0; cyc(); endtask
  task automatic p_b(); b_pulse = 1'b1; cyc(); b_pulse = 1'b0; cyc(); endtask
  task automatic p_c(); c_pulse = 1'b1; cyc(); c_pulse = 1'b0; cyc(); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_en = 0; a_mov = 0; a_pulse = 0; a_ack = 0;
    b_en = 0; b_mov = 0; b_pulse = 0; b_ack = 1;
    c_en = 0; c_mov = 0; c_pulse = 0; c_ack = 0;
    cyc(); cyc();
    expect_st("reset_a", 0, 0, 0, 0, 0, 0, 0);
    expect_st("reset_b", 1, 0, 0, 0, 0, 0, 0);
    expect_st("reset_c", 2, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc();

    // A: free window of 3 minutes, then one unit per minute.
    a_en = 1'b1; cyc();
    expect_st("a_free_entry", 0, 0, 0, 0, 0, 0, 0);
    p_a(); expect_st("a_pulse1", 0, 1, 0, 0, 0, 0, 0);
    p_a(); expect_st("a_pulse2", 0, 2, 0, 0, 0, 0, 0);
    p_a(); expect_st("a_pulse3_bill_unbilled", 0, 3, 0, 0, 1, 0, 0);
    p_a(); expect_st("a_pulse4_first_charge", 0, 4, 1, 0, 1, 0, 0);
    p_a(); expect_st("a_pulse5_pending2", 0, 5, 1, 0, 1, 0, 0);

    // A: ack every 4 cycles drains 2 pending units.
    repeat (3) cyc();
    a_ack = 1'b1; cyc(); a_ack = 1'b0;
    expect_st("a_ack1_still_req", 0, 5, 1, 0, 1, 0, 1);
    repeat (3) cyc();
    a_ack = 1'b1; cyc(); a_ack = 1'b0;
    expect_st("a_ack2_req_drop", 0, 5, 0, 0, 1, 0, 2);
    a_ack = 1'b1; cyc(); a_ack = 1'b0; cyc();
    expect_st("a_ack_ignored", 0, 5, 0, 0, 1, 0, 2);

    // A: moving suppresses counting.
    a_mov = 1'b1;
    repeat (10) p_a();
    expect_st("a_moving_hold", 0, 5, 0, 0, 1, 0, 2);
    a_mov = 1'b0;
    p_a(); expect_st("a_stopped_again", 0, 6, 1, 0, 1, 0, 2);
    a_ack = 1'b1; cyc(); a_ack = 1'b0;
    expect_st("a_ack3", 0, 6, 0, 0, 1, 0, 3);

    // A: tick and accepted ack in the same cycle keep pending at 1.
    p_a(); expect_st("a_pending1", 0, 7, 1, 0, 1, 0, 3);
    a_pulse = 1'b1; a_ack = 1'b1; cyc(); a_pulse = 1'b0; a_ack = 1'b0;
    expect_st("a_tick_and_ack", 0, 8, 1, 0, 1, 0, 4);
    cyc();
    expect_st("a_tick_and_ack_hold", 0, 8, 1, 0, 1, 0, 4);

    // B: 3-bit counter saturates at 7, ack tied high.
    b_en = 1'b1; cyc();
    expect_st("b_bill_direct", 1, 0, 0, 0, 1, 0, 0);
    repeat (6) p_b();
    expect_st("b_pulse6", 1, 6, 0, 0, 1, 0, 6);
    p_b(); expect_st("b_pulse7_sat", 1, 7, 0, 1, 1, 0, 7);
    repeat (3) p_b();
    expect_st("b_pulses_ignored", 1, 7, 0, 1, 1, 0, 7);

    // C: 2-bit pending saturates, then drains after trip end.
    c_en = 1'b1; cyc();
    repeat (3) p_c();
    expect_st("c_pending3", 2, 3, 1, 0, 1, 0, 0);
    p_c(); expect_st("c_pend_ovf", 2, 4, 1, 0, 1, 1, 0);
    c_en = 1'b0; cyc(); cyc();
    expect_st("c_trip_end", 2, 0, 1, 0, 0, 1, 0);
    c_ack = 1'b1; cyc(); cyc();
    expect_st("c_drain2", 2, 0, 1, 0, 0, 1, 2);
    cyc(); c_ack = 1'b0;
    expect_st("c_drain3", 2, 0, 0, 0, 0, 1, 3);

    // Reset mid-handshake on A (pending 1), asynchronous.
    c_en = 1'b1; cyc(); p_c();
    rst = 1'b1; #1;
    expect_st("a_async_reset", 0, 0, 0, 0, 0, 0, 4);
    expect_st("c_async_reset", 2, 0, 0, 0, 0, 0, 3);
    #1;
    -> chk_ev;
    #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wait_fare_timer.md
Name: wait_fare_timer

Overview:
Consumer end of the minute-pulse interface driven by the frequency divider. Counts waiting minutes while the taxi is engaged but stopped, applies a free-wait window, then issues per-step charge requests to the fare accumulator over a req/ack handshake. It also returns the saturation flag that drives the divider's `max` input, so the divider stops when waiting time is maxed out.

Parameters:
- FREE_MIN, 3, free waiting minutes before billing starts (0 = bill from first minute)
- BILL_STEP, 1, waiting minutes per charge unit (>=1)
- CNT_W, 8, width of wait_min
- PEND_W, 4, width of pending-charge counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  trip in service; 0 ends trip
- moving  in  1  vehicle moving; minutes are not counted while 1
- min_pulse  in  1  one-cycle minute strobe from divider
- charge_ack  in  1  fare accumulator accepts one charge unit
- charge_req  out  1  at least one charge unit pending
- wait_min  out  CNT_W  waiting minutes this trip
- sat  out  1  wait_min at all-ones; wired to divider `max`
- billing  out  1  FSM in BILL state
- pend_ovf  out  1  sticky: charge unit lost to pending saturation

Behaviour:
- Reset: all outputs 0, FSM IDLE, step_cnt 0, pending 0. Reset mid-handshake drops pending charges.
- tick = en & ~moving & min_pulse & ~sat, evaluated combinationally each cycle.
- FSM states: IDLE, FREE, BILL.
  - IDLE: go to FREE when en=1, or directly to BILL if FREE_MIN=0.
  - FREE: on a tick with wait_min==FREE_MIN-1, go to BILL.
  - FREE/BILL: en=0 returns to IDLE next cycle.
- wait_min / step_cnt:
  - wait_min increments on tick and holds at 2^CNT_W-1.
  - In IDLE, wait_min and step_cnt clear to 0.
  - sat = (wait_min == all-ones), registered along with wait_min. Once sat=1, ticks are ignored and no further charges are generated.
- Billing: in BILL, step_cnt counts ticks. A tick with step_cnt==BILL_STEP-1 adds one charge to pending and clears step_cnt. The tick that moves FREE->BILL is a free minute and is not billed.
- Handshake: charge_req = (pending != 0), registered.
  - An ack is accepted only when charge_req=1, and decrements pending. An ack while charge_req=0 is ignored.
  - Simultaneous add and accepted ack: pending unchanged.
  - Latency: a tick at cycle n raises charge_req and updates wait_min at n+1.
  - With pending=1, an ack at cycle n drops charge_req at n+1.
- Pending saturation: pending holds at 2^PEND_W-1. An add at full (with no simultaneous ack) sets pend_ovf, which clears only on rst.
- Trip end: pending charges are not discarded in IDLE. The handshake continues until pending drains.
- billing = (state == BILL).

Optional Feature:
- Macro: NIGHT_RATE_EN
- Defined: adds input port `night`. Each billing step adds 2 charge units, clamped at the saturation value; pend_ovf sets if any unit is lost.
- Undefined: no `night` port, and each step adds 1 unit.

Decomposition:
- Package taxi_pkg: state encoding (IDLE/FREE/BILL), default CNT_W/PEND_W constants, charge-unit increment constants (1 and 2).
- Sub-module charge_queue: pending counter, saturation, pend_ovf and req/ack logic. Parameter PEND_W; inputs add (count 0..2) and charge_ack; outputs charge_req, pend_ovf.

Test Plan:
- Defaults; en=1, moving=0, ack held 0, 5 min_pulses -> wait_min=5, FREE->BILL on the 3rd pulse, pending=2, charge_req=1 from the cycle after the 4th pulse.
- Continue the previous case with a one-cycle ack every 4 cycles -> two accepted acks, charge_req low the cycle after the 2nd ack, pend_ovf=0.
- moving=1 during 10 pulses -> wait_min unchanged, no charges. Then moving=0 and 1 pulse -> wait_min increments by 1.
- CNT_W=3, FREE_MIN=0, ack tied 1, 10 pulses -> wait_min stops at 7, sat=1 after the 7th pulse, exactly 7 charges acked, later pulses ignored.
- PEND_W=2, ack=0, FREE_MIN=0, 4 pulses -> pending=3, pend_ovf=1 after the 4th. Then en=0 -> wait_min=0, charge_req stays 1 until 3 acks.
- Tick and ack in the same cycle with pending=1 -> pending stays 1, charge_req stays 1. Then assert rst mid-handshake -> charge_req, wait_min, pend_ovf all 0 immediately.
